pipe_mips32_fwd: RTL and testbench
==================================

Name: pipe_mips32_fwd

Overview:
- Single-clock, 5-stage (IF/ID/EX/MEM/WB) MIPS32-subset pipeline; same instruction encoding and opcode set as the existing two-phase core.
- Adds operand forwarding, load-use interlock, branch flush, async reset, external instruction/data memory ports, performance counters and a debug register read port.
- Parametrised in datapath width and address widths.

Parameters:
XLEN, 32, datapath/register width (>=16)
IMEM_AW, 10, instruction word-address width
DMEM_AW, 10, data word-address width
RESET_PC, 0, PC value after reset
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
imem_addr  out  IMEM_AW  fetch word address (= PC)
imem_rdata  in  32  instruction, combinational read of imem_addr
dmem_addr  out  DMEM_AW  data word address (EX/MEM ALU result, low bits)
dmem_wdata  out  XLEN  store data
dmem_we  out  1  store strobe, memory writes at rising clk when high
dmem_re  out  1  load strobe
dmem_rdata  in  XLEN  load data, combinational read of dmem_addr
dbg_raddr  in  5  debug register index
dbg_rdata  out  XLEN  Reg[dbg_raddr], combinational; 0 for index 0
halted  out  1  high once HLT retires, sticky until rst
instret  out  CNT_W  retired instruction count
stall_cnt  out  CNT_W  load-use stall cycles

Behaviour:
- Encoding: op[31:26], rs[25:21], rt[20:16], rd[15:11], imm[15:0] sign-extended to XLEN.
- Opcodes: ADD 00, SUB 01, AND 02, OR 03, SLT 04, MUL 05 (rd = rs op rt); ADDI 0A, SUBI 0B, SLTI 0C (rt = rs op imm); LW 08 (rt = M[rs+imm]); SW 09 (M[rs+imm] = rt); BNEQZ 0D, BEQZ 0E (target = PC+1+imm); HLT 3F. Any other opcode is treated as HLT.
- SLT/SLTI compare signed; result is 1 or 0. MUL keeps low XLEN bits. All other arithmetic wraps modulo 2^XLEN. PC wraps modulo 2^IMEM_AW.
- Reset (async): PC=RESET_PC, all pipeline registers hold bubbles (no side effects), all 32 registers = 0, halted=0, counters=0, dmem_we=0, dmem_re=0.
- R0 always reads 0; writes to R0 are discarded.
- ID reads the register file write-through: a WB write in the same cycle is visible.
- EX forwarding priority: EX/MEM result first, then MEM/WB result, then ID/EX value. Applies to both rs and rt, including SW store data. Forwarding is never taken from a bubble, a store, a branch, or R0.
- Load-use: when the instruction in ID reads (rs, or rt for R-type/SW/branch-free rt use) the rt of an LW sitting in EX, hold PC and IF/ID, insert one bubble into EX, and increment stall_cnt once per stall cycle.
- Branches resolve in EX; cond = (rs == 0).
  - Taken: PC <= target, IF/ID and ID/EX squashed to bubbles; 2-cycle penalty.
  - Not taken: no penalty.
  - A taken branch overrides a coincident load-use stall.
- HLT decoded in ID: PC freezes and younger fetches are squashed. Older instructions drain normally. halted rises on the cycle after HLT reaches WB. While halted, nothing changes state, dmem_we=0, dmem_re=0.
- instret increments once per non-bubble instruction in WB, HLT included. Both counters saturate at all-ones.
- Reset asserted mid-operation aborts everything immediately. A store whose clk edge coincides with reset assertion is not performed.

Test Plan:
- Load/use chain. Program: ADDI R1,R0,120; LW R2,0(R1); ADDI R2,R2,45; SW R2,1(R1); HLT, with dmem[120]=105 and no filler instructions. Required: dmem[121]=150, R1=120, R2=150, stall_cnt=1, instret=5, halted=1.
- Back-to-back forwarding. Program: ADDI R1,R0,7; ADD R2,R1,R1; SUB R3,R2,R1; MUL R4,R3,R2; HLT. Required: R2=14, R3=7, R4=98, stall_cnt=0.
- Branch loop. Program: ADDI R1,R0,3; ADDI R2,R0,0; loop: ADDI R2,R2,5; SUBI R1,R1,1; BNEQZ R1,-3; HLT. Required: R2=15, R1=0. Instructions behind each taken branch never write, verified via instret=12.
- R0 and signed compare. Program: ADDI R0,R0,9; ADDI R5,R0,-1; SLTI R6,R5,0; SLT R7,R0,R5; HLT. Required: R0=0, R5=all-ones, R6=1, R7=0.
- Invalid opcode 0x15 followed by ADDI R1,R0,1. Required: halted=1, R1 unchanged (0), instret=1.
- Reset pulse mid-loop, held for 3 cycles. Required: PC=RESET_PC, registers=0, counters=0, no dmem_we during reset; the program then reruns to the same final state.

Source files
------------

// File: rtl/pipe_mips32_fwd.sv
// Single-clock 5-stage MIPS32-subset pipeline: forwarding, load-use interlock, EX branch
// resolution with flush, HLT drain, performance counters and a debug register read port.
module pipe_mips32_fwd #(
    parameter int XLEN     = 32,
    parameter int IMEM_AW  = 10,
    parameter int DMEM_AW  = 10,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 32
) (
    input  logic               clk,
    input  logic               rst,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [31:0]        imem_rdata,
    output logic [DMEM_AW-1:0] dmem_addr,
    output logic [XLEN-1:0]    dmem_wdata,
    output logic               dmem_we,
    output logic               dmem_re,
    input  logic [XLEN-1:0]    dmem_rdata,
    input  logic [4:0]         dbg_raddr,
    output logic [XLEN-1:0]    dbg_rdata,
    output logic               halted,
    output logic [CNT_W-1:0]   instret,
    output logic [CNT_W-1:0]   stall_cnt
);
    localparam logic [5:0] OP_ADD = 6'h00, OP_SUB = 6'h01, OP_AND = 6'h02, OP_OR = 6'h03;
    localparam logic [5:0] OP_SLT = 6'h04, OP_MUL = 6'h05, OP_LW = 6'h08, OP_SW = 6'h09;
    localparam logic [5:0] OP_ADDI = 6'h0A, OP_SUBI = 6'h0B, OP_SLTI = 6'h0C;
    localparam logic [5:0] OP_BNEQZ = 6'h0D, OP_BEQZ = 6'h0E;
    localparam logic [IMEM_AW-1:0] PC_RST = IMEM_AW'(RESET_PC);
    localparam logic [IMEM_AW-1:0] PC_ONE = {{(IMEM_AW-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CNT_MAX = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]    X_ZERO = {XLEN{1'b0}};

    typedef struct packed {
        logic valid; logic [31:0] ir; logic [IMEM_AW-1:0] pc;
    } ifid_t;
    typedef struct packed {
        logic valid; logic [5:0] op; logic [4:0] rs; logic [4:0] rt; logic [4:0] dest;
        logic wr; logic is_lw; logic is_sw; logic is_br; logic is_hlt;
        logic [XLEN-1:0] a; logic [XLEN-1:0] b; logic [XLEN-1:0] imm; logic [IMEM_AW-1:0] pc;
    } idex_t;
    typedef struct packed {
        logic valid; logic [XLEN-1:0] alu; logic [XLEN-1:0] sdata; logic [4:0] dest;
        logic wr; logic is_lw; logic we; logic re; logic is_hlt;
    } exmem_t;
    typedef struct packed {
        logic valid; logic [XLEN-1:0] result; logic [4:0] dest; logic wr; logic is_hlt;
    } memwb_t;

    localparam ifid_t IFID_BUBBLE = {$bits(ifid_t){1'b0}};
    localparam idex_t IDEX_BUBBLE = {$bits(idex_t){1'b0}};

    logic [XLEN-1:0]    rf_q [32];
    logic [IMEM_AW-1:0] pc_q, pc_d;
    ifid_t              ifid_q, ifid_d;
    idex_t              idex_q, idex_d, id_dec_s;
    exmem_t             exmem_q, exmem_d;
    memwb_t             memwb_q, memwb_d;
    logic               freeze_q, freeze_d, halted_q, halted_d;
    logic [CNT_W-1:0]   instret_q, instret_d, stall_cnt_q, stall_cnt_d;

    logic               wb_we_s, uses_rs_s, uses_rt_s, is_r_s, is_i_s, load_use_s, br_taken_s;
    logic [XLEN-1:0]    ex_a_s, ex_b_s, ex_op2_s, ex_alu_s;
    logic [IMEM_AW-1:0] br_target_s;

    assign wb_we_s = memwb_q.valid & memwb_q.wr & (memwb_q.dest != 5'd0) & ~halted_q;

    // ID: decode and write-through register read
    always_comb begin
        id_dec_s  = IDEX_BUBBLE;
        is_r_s    = ifid_q.ir[31:26] <= OP_MUL;
        is_i_s    = (ifid_q.ir[31:26] >= OP_ADDI) && (ifid_q.ir[31:26] <= OP_SLTI);
        id_dec_s.op     = ifid_q.ir[31:26];
        id_dec_s.rs     = ifid_q.ir[25:21];
        id_dec_s.rt     = ifid_q.ir[20:16];
        id_dec_s.dest   = is_r_s ? ifid_q.ir[15:11] : ifid_q.ir[20:16];
        id_dec_s.is_lw  = id_dec_s.op == OP_LW;
        id_dec_s.is_sw  = id_dec_s.op == OP_SW;
        id_dec_s.is_br  = (id_dec_s.op == OP_BNEQZ) || (id_dec_s.op == OP_BEQZ);
        id_dec_s.wr     = is_r_s | is_i_s | id_dec_s.is_lw;
        id_dec_s.is_hlt = ~(id_dec_s.wr | id_dec_s.is_sw | id_dec_s.is_br);
        id_dec_s.imm    = XLEN'($signed(ifid_q.ir[15:0]));
        id_dec_s.pc     = ifid_q.pc;
        uses_rs_s = ~id_dec_s.is_hlt;
        uses_rt_s = is_r_s | id_dec_s.is_sw;
        if (id_dec_s.rs == 5'd0) id_dec_s.a = X_ZERO;
        else if (wb_we_s && memwb_q.dest == id_dec_s.rs) id_dec_s.a = memwb_q.result;
        else id_dec_s.a = rf_q[id_dec_s.rs];
        if (id_dec_s.rt == 5'd0) id_dec_s.b = X_ZERO;
        else if (wb_we_s && memwb_q.dest == id_dec_s.rt) id_dec_s.b = memwb_q.result;
        else id_dec_s.b = rf_q[id_dec_s.rt];
        id_dec_s.valid  = ifid_q.valid;
        id_dec_s.wr     = id_dec_s.wr & ifid_q.valid;
        id_dec_s.is_lw  = id_dec_s.is_lw & ifid_q.valid;
        id_dec_s.is_sw  = id_dec_s.is_sw & ifid_q.valid;
        id_dec_s.is_br  = id_dec_s.is_br & ifid_q.valid;
        id_dec_s.is_hlt = id_dec_s.is_hlt & ifid_q.valid;
        load_use_s = ifid_q.valid & idex_q.valid & idex_q.is_lw & (idex_q.dest != 5'd0) &
                     ((uses_rs_s & (id_dec_s.rs == idex_q.dest)) |
                      (uses_rt_s & (id_dec_s.rt == idex_q.dest)));
    end

    // EX: operand forwarding (EX/MEM before MEM/WB), ALU and branch resolution
    always_comb begin
        if (exmem_q.valid && exmem_q.wr && !exmem_q.is_lw && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rs)
            ex_a_s = exmem_q.alu;
        else if (memwb_q.valid && memwb_q.wr && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rs)
            ex_a_s = memwb_q.result;
        else
            ex_a_s = idex_q.a;
        if (exmem_q.valid && exmem_q.wr && !exmem_q.is_lw && exmem_q.dest != 5'd0 && exmem_q.dest == idex_q.rt)
            ex_b_s = exmem_q.alu;
        else if (memwb_q.valid && memwb_q.wr && memwb_q.dest != 5'd0 && memwb_q.dest == idex_q.rt)
            ex_b_s = memwb_q.result;
        else
            ex_b_s = idex_q.b;
        ex_op2_s = (idex_q.op <= OP_MUL) ? ex_b_s : idex_q.imm;
        case (idex_q.op)
            OP_ADD, OP_ADDI, OP_LW, OP_SW: ex_alu_s = ex_a_s + ex_op2_s;
            OP_SUB, OP_SUBI:               ex_alu_s = ex_a_s - ex_op2_s;
            OP_AND:                        ex_alu_s = ex_a_s & ex_op2_s;
            OP_OR:                         ex_alu_s = ex_a_s | ex_op2_s;
            OP_SLT, OP_SLTI:               ex_alu_s = {{(XLEN-1){1'b0}}, $signed(ex_a_s) < $signed(ex_op2_s)};
            OP_MUL:                        ex_alu_s = ex_a_s * ex_op2_s;
            default:                       ex_alu_s = X_ZERO;
        endcase
        br_taken_s  = idex_q.valid & idex_q.is_br &
                      ((idex_q.op == OP_BEQZ) ? (ex_a_s == X_ZERO) : (ex_a_s != X_ZERO));
        br_target_s = idex_q.pc + PC_ONE + idex_q.imm[IMEM_AW-1:0];
    end

    // Next-state: flush beats stall, stall beats HLT freeze, everything holds once halted
    always_comb begin
        pc_d = pc_q; ifid_d = ifid_q; idex_d = id_dec_s; freeze_d = freeze_q;
        exmem_d = '{valid: idex_q.valid, alu: ex_alu_s, sdata: ex_b_s, dest: idex_q.dest,
                    wr: idex_q.wr, is_lw: idex_q.is_lw, we: idex_q.is_sw, re: idex_q.is_lw,
                    is_hlt: idex_q.is_hlt};
        memwb_d = '{valid: exmem_q.valid, result: exmem_q.is_lw ? dmem_rdata : exmem_q.alu,
                    dest: exmem_q.dest, wr: exmem_q.wr, is_hlt: exmem_q.is_hlt};
        halted_d    = halted_q | (memwb_q.valid & memwb_q.is_hlt);
        instret_d   = (memwb_q.valid && instret_q != CNT_MAX) ? instret_q + CNT_ONE : instret_q;
        stall_cnt_d = stall_cnt_q;
        if (halted_q) begin
            idex_d = idex_q; exmem_d = exmem_q; memwb_d = memwb_q; instret_d = instret_q;
        end else if (br_taken_s) begin
            pc_d = br_target_s; ifid_d = IFID_BUBBLE; idex_d = IDEX_BUBBLE;
        end else if (load_use_s) begin
            idex_d = IDEX_BUBBLE;
            stall_cnt_d = (stall_cnt_q != CNT_MAX) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        end else if (freeze_q || id_dec_s.is_hlt) begin
            ifid_d = IFID_BUBBLE; freeze_d = 1'b1;
        end else begin
            pc_d = pc_q + PC_ONE;
            ifid_d = '{valid: 1'b1, ir: imem_rdata, pc: pc_q};
        end
    end

    // Pipeline, control and counter state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= PC_RST; ifid_q <= IFID_BUBBLE; idex_q <= IDEX_BUBBLE;
            exmem_q <= {$bits(exmem_t){1'b0}}; memwb_q <= {$bits(memwb_t){1'b0}};
            freeze_q <= 1'b0; halted_q <= 1'b0;
            instret_q <= {CNT_W{1'b0}}; stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            pc_q <= pc_d; ifid_q <= ifid_d; idex_q <= idex_d; exmem_q <= exmem_d; memwb_q <= memwb_d;
            freeze_q <= freeze_d; halted_q <= halted_d;
            instret_q <= instret_d; stall_cnt_q <= stall_cnt_d;
        end
    end

    // Register file, written from WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= X_ZERO;
        end else if (wb_we_s) begin
            rf_q[memwb_q.dest] <= memwb_q.result;
        end
    end

    assign imem_addr  = pc_q;
    assign dmem_addr  = exmem_q.alu[DMEM_AW-1:0];
    assign dmem_wdata = exmem_q.sdata;
    assign dmem_we    = exmem_q.valid & exmem_q.we;
    assign dmem_re    = exmem_q.valid & exmem_q.re;
    assign dbg_rdata  = (dbg_raddr == 5'd0) ? X_ZERO : rf_q[dbg_raddr];
    assign halted     = halted_q;
    assign instret    = instret_q;
    assign stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_pipe_mips32_fwd.sv
// Directed self-checking bench for pipe_mips32_fwd: runs small programs from the test plan
// out of behavioural instruction/data memories and checks registers, memory and counters.
module tb_pipe_mips32_fwd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  imem_addr, dmem_addr;
    logic [31:0] imem_rdata, dmem_wdata, dmem_rdata, dbg_rdata, instret, stall_cnt;
    logic        dmem_we, dmem_re, halted;
    logic [4:0]  dbg_raddr = 5'd0;

    logic [31:0] imem [1024];
    logic [31:0] dmem [1024];
    int checks = 0;
    int passes = 0;

    localparam logic [31:0] HLT = 32'hFC00_0000;

    pipe_mips32_fwd dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_we(dmem_we), .dmem_re(dmem_re),
        .dmem_rdata(dmem_rdata), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata),
        .halted(halted), .instret(instret), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    always @(posedge clk) if (dmem_we) dmem[dmem_addr] <= dmem_wdata;

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, rd, 11'd0};
    endfunction
    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rs, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Filler (ADDI R9,R0,99) everywhere so any wrongly retired younger fetch shows up in R9.
    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) begin
            imem[i] = enc_i(6'h0A, 5'd9, 5'd0, 16'd99);
            dmem[i] = 32'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic read_reg(input logic [4:0] idx, output logic [31:0] val);
        dbg_raddr = idx; #1; val = dbg_rdata;
    endtask

    task automatic run_to_halt(input string name);
        for (int i = 0; i < 300 && !halted; i++) @(negedge clk);
        checks++;
        if (halted !== 1'b1) $display("FAIL %s_halt: halted=%b required 1 within 300 cycles", name, halted);
        else passes++;
    endtask

    task automatic load_loop();
        clear_mem();
        imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd3);
        imem[1] = enc_i(6'h0A, 5'd2, 5'd0, 16'd0);
        imem[2] = enc_i(6'h0A, 5'd2, 5'd2, 16'd5);
        imem[3] = enc_i(6'h0B, 5'd1, 5'd1, 16'd1);
        imem[4] = enc_i(6'h0D, 5'd0, 5'd1, 16'hFFFD);
        imem[5] = HLT;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        clear_mem();
        @(negedge clk); #1;
        checks++; if (imem_addr !== 10'd0 || halted !== 1'b0 || dmem_we !== 1'b0 || dmem_re !== 1'b0)
            $display("FAIL reset_ctrl: pc=%0d halted=%b we=%b re=%b required 0/0/0/0", imem_addr, halted, dmem_we, dmem_re);
        else passes++;
        checks++; if (instret !== 32'd0 || stall_cnt !== 32'd0)
            $display("FAIL reset_cnt: instret=%0d stall=%0d required 0/0", instret, stall_cnt);
        else passes++;
        read_reg(5'd1, v);
        checks++; if (v !== 32'd0) $display("FAIL reset_r1: got %0d required 0", v); else passes++;
        rst = 1'b0;
    endtask

    task automatic test_load_use();
        logic [31:0] v;
        logic [9:0]  pc_h;
        logic [31:0] ir_h;
        logic        we_seen = 1'b0;
        clear_mem();
        imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd120);
        imem[1] = enc_i(6'h08, 5'd2, 5'd1, 16'd0);
        imem[2] = enc_i(6'h0A, 5'd2, 5'd2, 16'd45);
        imem[3] = enc_i(6'h09, 5'd2, 5'd1, 16'd1);
        imem[4] = HLT;
        dmem[120] = 32'd105;
        do_reset();
        run_to_halt("load_use");
        checks++; if (dmem[121] !== 32'd150) $display("FAIL lu_mem121: got %0d required 150", dmem[121]); else passes++;
        read_reg(5'd1, v);
        checks++; if (v !== 32'd120) $display("FAIL lu_r1: got %0d required 120", v); else passes++;
        read_reg(5'd2, v);
        checks++; if (v !== 32'd150) $display("FAIL lu_r2: got %0d required 150", v); else passes++;
        read_reg(5'd9, v);
        checks++; if (v !== 32'd0) $display("FAIL lu_r9_squash: got %0d required 0", v); else passes++;
        checks++; if (stall_cnt !== 32'd1) $display("FAIL lu_stall_cnt: got %0d required 1", stall_cnt); else passes++;
        checks++; if (instret !== 32'd5) $display("FAIL lu_instret: got %0d required 5", instret); else passes++;
        pc_h = imem_addr; ir_h = instret;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dmem_we || dmem_re) we_seen = 1'b1;
        end
        checks++; if (imem_addr !== pc_h || instret !== ir_h || halted !== 1'b1 || we_seen !== 1'b0)
            $display("FAIL lu_halt_frozen: pc=%0d/%0d instret=%0d/%0d halted=%b strobe=%b required equal,1,0",
                     imem_addr, pc_h, instret, ir_h, halted, we_seen);
        else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        clear_mem();
        imem[0] = enc_i(6'h0A, 5'd1, 5'd0, 16'd7);
        imem[1] = enc_r(6'h00, 5'd2, 5'd1, 5'd1);
        imem[2] = enc_r(6'h01, 5'd3, 5'd2, 5'd1);
        imem[3] = enc_r(6'h05, 5'd4, 5'd3, 5'd2);
        imem[4] = HLT;
        do_reset();
        run_to_halt("b2b");
        read_reg(5'd2, v);
        checks++; if (v !== 32'd14) $display("FAIL b2b_r2: got %0d required 14", v); else passes++;
        read_reg(5'd3, v);
        checks++; if (v !== 32'd7) $display("FAIL b2b_r3: got %0d required 7", v); else passes++;
        read_reg(5'd4, v);
        checks++; if (v !== 32'd98) $display("FAIL b2b_r4: got %0d required 98", v); else passes++;
        checks++; if (stall_cnt !== 32'd0 || instret !== 32'd5)
            $display("FAIL b2b_counters: stall=%0d instret=%0d required 0/5", stall_cnt, instret);
        else passes++;
    endtask

    task automatic test_branch_loop();
        logic [31:0] v;
        load_loop();
        do_reset();
        run_to_halt("loop");
        read_reg(5'd2, v);
        checks++; if (v !== 32'd15) $display("FAIL loop_r2: got %0d required 15", v); else passes++;
        read_reg(5'd1, v);
        checks++; if (v !== 32'd0) $display("FAIL loop_r1: got %0d required 0", v); else passes++;
        read_reg(5'd9, v);
        checks++; if (v !== 32'd0) $display("FAIL loop_r9_squash: got %0d required 0", v); else passes++;
        checks++; if (instret !== 32'd12) $display("FAIL loop_instret: got %0d required 12", instret); else passes++;
    endtask

    task automatic test_r0_slt();
        logic [31:0] v;
        clear_mem();
        imem[0] = enc_i(6'h0A, 5'd0, 5'd0, 16'd9);
        imem[1] = enc_i(6'h0A, 5'd5, 5'd0, 16'hFFFF);
        imem[2] = enc_i(6'h0C, 5'd6, 5'd5, 16'd0);
        imem[3] = enc_r(6'h04, 5'd7, 5'd0, 5'd5);
        imem[4] = HLT;
        do_reset();
        run_to_halt("r0slt");
        read_reg(5'd0, v);
        checks++; if (v !== 32'd0) $display("FAIL r0_value: got %0d required 0", v); else passes++;
        read_reg(5'd5, v);
        checks++; if (v !== 32'hFFFF_FFFF) $display("FAIL r0_r5: got %h required ffffffff", v); else passes++;
        read_reg(5'd6, v);
        checks++; if (v !== 32'd1) $display("FAIL slti_r6: got %0d required 1", v); else passes++;
        read_reg(5'd7, v);
        checks++; if (v !== 32'd0) $display("FAIL slt_r7: got %0d required 0", v); else passes++;
    endtask

    task automatic test_invalid_opcode();
        logic [31:0] v;
        clear_mem();
        imem[0] = {6'h15, 26'd0};
        imem[1] = enc_i(6'h0A, 5'd1, 5'd0, 16'd1);
        do_reset();
        run_to_halt("invalid");
        read_reg(5'd1, v);
        checks++; if (v !== 32'd0) $display("FAIL inv_r1: got %0d required 0", v); else passes++;
        checks++; if (instret !== 32'd1) $display("FAIL inv_instret: got %0d required 1", instret); else passes++;
    endtask

    task automatic test_reset_mid_loop();
        logic [31:0] v1, v2;
        logic        we_seen = 1'b0;
        load_loop();
        do_reset();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1; if (dmem_we) we_seen = 1'b1;
            @(negedge clk);
        end
        #1;
        checks++; if (we_seen !== 1'b0) $display("FAIL rst_mid_we: dmem_we seen=%b required 0", we_seen); else passes++;
        checks++; if (imem_addr !== 10'd0 || instret !== 32'd0 || stall_cnt !== 32'd0 || halted !== 1'b0)
            $display("FAIL rst_mid_state: pc=%0d instret=%0d stall=%0d halted=%b required 0/0/0/0",
                     imem_addr, instret, stall_cnt, halted);
        else passes++;
        read_reg(5'd1, v1);
        read_reg(5'd2, v2);
        checks++; if (v1 !== 32'd0 || v2 !== 32'd0) $display("FAIL rst_mid_regs: r1=%0d r2=%0d required 0/0", v1, v2); else passes++;
        @(negedge clk); rst = 1'b0;
        run_to_halt("rerun");
        read_reg(5'd1, v1);
        read_reg(5'd2, v2);
        checks++; if (v1 !== 32'd0 || v2 !== 32'd15 || instret !== 32'd12)
            $display("FAIL rerun_final: r1=%0d r2=%0d instret=%0d required 0/15/12", v1, v2, instret);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_back_to_back();
        test_branch_loop();
        test_r0_slt();
        test_invalid_opcode();
        test_reset_mid_loop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
